// File: rtl/pipeline_pkg.sv
// Shared pipeline types: memory-stage FSM states and the W-stage control bundle.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_DATA = 2'd2
  } mem_state_e;

  localparam logic [4:0] REG_RA = 5'd31;

  // Width-independent part of the W bundle; data words live beside it.
  typedef struct packed {
    logic       reg_write;
    logic       misalign;
    logic       mem_to_reg;
    logic [4:0] write_reg;
  } w_ctrl_t;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer.
module mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             sel_i,
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/writeback_reg.sv
// M/W pipeline register. A bubble clears the write-enable and misalign flags
// and holds every other field.
module writeback_reg
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  bubble_i,
  input  w_ctrl_t               ctrl_i,
  input  logic [DATA_WIDTH-1:0] alu_out_i,
  input  logic                  load_done_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output w_ctrl_t               ctrl_o,
  output logic [DATA_WIDTH-1:0] alu_out_o,
  output logic [DATA_WIDTH-1:0] read_data_o
);

  w_ctrl_t               ctrl_q;
  logic [DATA_WIDTH-1:0] alu_out_q;
  logic [DATA_WIDTH-1:0] read_data_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_q      <= '0;
      alu_out_q   <= '0;
      read_data_q <= '0;
    end else begin
      if (bubble_i) begin
        ctrl_q.reg_write <= 1'b0;
        ctrl_q.misalign  <= 1'b0;
      end else begin
        ctrl_q    <= ctrl_i;
        alu_out_q <= alu_out_i;
      end
      if (load_done_i) begin
        read_data_q <= rdata_i;
      end
    end
  end

  assign ctrl_o      = ctrl_q;
  assign alu_out_o   = alu_out_q;
  assign read_data_o = read_data_q;

endmodule

// File: rtl/mem_access.sv
// Memory stage: drives the req/gnt/rvalid data port, stalls until the access
// completes and registers the W bundle feeding writeback and forwarding.
module mem_access
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  reg_write_m_i,
  input  logic                  mem_write_m_i,
  input  logic                  mem_to_reg_m_i,
  input  logic [DATA_WIDTH-1:0] alu_out_m_i,
  input  logic [DATA_WIDTH-1:0] write_data_m_i,
  input  logic [4:0]            write_reg_m_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  output logic                  stall_m_o,
  output logic                  misalign_w_o,
  output logic                  reg_write_w_o,
  output logic [4:0]            write_reg_w_o,
  output logic [DATA_WIDTH-1:0] result_w_o
);

  mem_state_e state_q, state_d;

  logic mem_op, misalign, req, load_done, done;

  assign mem_op   = mem_write_m_i | mem_to_reg_m_i;
  assign misalign = mem_op & (alu_out_m_i[1:0] != 2'b00);

  // Gated by reset so the port and the hazard unit see a quiet stage while held in reset.
  assign req = rst_i & (((state_q == IDLE) & mem_op & ~misalign) | (state_q == WAIT_GNT));

  assign load_done = (state_q == WAIT_DATA) & dmem_rvalid_i;
  assign done      = (req & mem_write_m_i & dmem_gnt_i) | load_done;

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (dmem_gnt_i) state_d = mem_write_m_i ? IDLE : WAIT_DATA;
          else            state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        if (dmem_gnt_i) state_d = mem_write_m_i ? IDLE : WAIT_DATA;
      end
      WAIT_DATA: begin
        if (dmem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = mem_write_m_i;
  assign dmem_addr_o  = alu_out_m_i[ADDR_WIDTH-1:0];
  assign dmem_wdata_o = write_data_m_i;
  assign stall_m_o    = rst_i & mem_op & ~misalign & ~done;

  w_ctrl_t               ctrl_m, ctrl_w;
  logic [DATA_WIDTH-1:0] alu_out_w, read_data_w;

  assign ctrl_m = '{reg_write:  reg_write_m_i & ~misalign,
                    misalign:   misalign,
                    mem_to_reg: mem_to_reg_m_i,
                    write_reg:  write_reg_m_i};

  writeback_reg #(.DATA_WIDTH(DATA_WIDTH)) u_writeback_reg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bubble_i    (stall_m_o),
    .ctrl_i      (ctrl_m),
    .alu_out_i   (alu_out_m_i),
    .load_done_i (load_done),
    .rdata_i     (dmem_rdata_i),
    .ctrl_o      (ctrl_w),
    .alu_out_o   (alu_out_w),
    .read_data_o (read_data_w)
  );

  mux2 #(.WIDTH(DATA_WIDTH)) u_result_mux (
    .sel_i (ctrl_w.mem_to_reg),
    .d0_i  (alu_out_w),
    .d1_i  (read_data_w),
    .y_o   (result_w_o)
  );

  assign misalign_w_o  = ctrl_w.misalign;
  assign reg_write_w_o = ctrl_w.reg_write;
  assign write_reg_w_o = ctrl_w.write_reg;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed cases plus randomized operations against a
// transaction-level model of stall length and the resulting W bundle.
module tb_mem_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        reg_write_m_i, mem_write_m_i, mem_to_reg_m_i;
  logic [31:0] alu_out_m_i, write_data_m_i;
  logic [4:0]  write_reg_m_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_m_o, misalign_w_o, reg_write_w_o;
  logic [4:0]  write_reg_w_o;
  logic [31:0] result_w_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  mem_access dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .reg_write_m_i  (reg_write_m_i),
    .mem_write_m_i  (mem_write_m_i),
    .mem_to_reg_m_i (mem_to_reg_m_i),
    .alu_out_m_i    (alu_out_m_i),
    .write_data_m_i (write_data_m_i),
    .write_reg_m_i  (write_reg_m_i),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i),
    .stall_m_o      (stall_m_o),
    .misalign_w_o   (misalign_w_o),
    .reg_write_w_o  (reg_write_w_o),
    .write_reg_w_o  (write_reg_w_o),
    .result_w_o     (result_w_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
    end
  endtask

  // One instruction held in M until it leaves. The memory grants g cycles
  // after the first request and, for loads, returns data r cycles after the grant.
  task automatic run_op(input logic rw, input logic mw, input logic mr,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                        input int g, input int r, input logic [31:0] rdata, input logic stray);
    logic aligned_mem, mis, exp_rw;
    int   stall_len;
    aligned_mem = (mw | mr) && (alu[1:0] == 2'b00);
    mis         = (mw | mr) && (alu[1:0] != 2'b00);
    stall_len   = !aligned_mem ? 0 : (mw ? g : g + r);
    exp_rw      = rw & ~mis;

    reg_write_m_i  = rw;
    mem_write_m_i  = mw;
    mem_to_reg_m_i = mr;
    alu_out_m_i    = alu;
    write_data_m_i = wd;
    write_reg_m_i  = rd;

    for (int k = 0; k <= stall_len; k++) begin
      dmem_gnt_i = aligned_mem && (k == g);
      if (aligned_mem && mr) begin
        dmem_rvalid_i = (k == g + r);
        dmem_rdata_i  = (k == g + r) ? rdata : $urandom;
      end else begin
        dmem_rvalid_i = stray ? 1'($urandom_range(0, 1)) : 1'b0;
        dmem_rdata_i  = $urandom;
      end
      @(negedge clk_i);
      check("stall", stall_m_o, (k < stall_len));
      check("req", dmem_req_o, (aligned_mem && k <= g));
      if (aligned_mem && k <= g) begin
        check("we", dmem_we_o, mw);
        check("addr", dmem_addr_o, alu);
        if (mw) check("wdata", dmem_wdata_o, wd);
      end
      @(posedge clk_i);
      #1;
      if (k < stall_len) begin
        check("bubble_rw", reg_write_w_o, 0);
        check("bubble_mis", misalign_w_o, 0);
      end
    end
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    check("w_rw", reg_write_w_o, exp_rw);
    check("w_mis", misalign_w_o, mis);
    check("w_rd", write_reg_w_o, rd);
    if (exp_rw) check("w_result", result_w_o, mr ? rdata : alu);
  endtask

  initial begin
    rst_i = 1'b0;
    reg_write_m_i = 0; mem_write_m_i = 0; mem_to_reg_m_i = 0;
    alu_out_m_i = 0; write_data_m_i = 0; write_reg_m_i = 0;
    dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h1111_2222;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_stall", stall_m_o, 0);
    check("rst_req", dmem_req_o, 0);
    check("rst_rw", reg_write_w_o, 0);
    check("rst_mis", misalign_w_o, 0);
    check("rst_rd", write_reg_w_o, 0);
    check("rst_result", result_w_o, 0);
    dmem_rvalid_i = 0;
    rst_i = 1'b1;

    // ALU, store with immediate grant, slow load, misaligned load, stray rvalid.
    run_op(1, 0, 0, 32'h1234, 0, 5'd8, 0, 0, 0, 0);
    run_op(0, 1, 0, 32'h40, 32'hDEADBEEF, 5'd0, 0, 0, 0, 0);
    run_op(1, 0, 1, 32'h80, 0, 5'd9, 2, 3, 32'hCAFEF00D, 0);
    run_op(1, 0, 1, 32'h82, 0, 5'd10, 0, 0, 0, 0);
    run_op(1, 0, 0, 32'h5A5A, 0, 5'd11, 0, 0, 0, 1);
    run_op(1, 0, 1, 32'h84, 0, 5'd12, 0, 1, 32'h0BADF00D, 0);
    run_op(0, 1, 0, 32'h43, 32'h1, 5'd0, 0, 0, 0, 0);

    // Reset while a load waits for data; the late rvalid must be ignored.
    reg_write_m_i = 1; mem_write_m_i = 0; mem_to_reg_m_i = 1;
    alu_out_m_i = 32'h100; write_reg_m_i = 5'd13; dmem_gnt_i = 1;
    @(negedge clk_i);
    check("mid_stall", stall_m_o, 1);
    @(posedge clk_i);
    #1;
    dmem_gnt_i = 0;
    #2;
    rst_i = 1'b0;
    reg_write_m_i = 0; mem_to_reg_m_i = 0; alu_out_m_i = 32'h55; write_reg_m_i = 5'd0;
    #1;
    check("mid_rst_stall", stall_m_o, 0);
    check("mid_rst_req", dmem_req_o, 0);
    check("mid_rst_rw", reg_write_w_o, 0);
    check("mid_rst_result", result_w_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    dmem_rvalid_i = 1; dmem_rdata_i = 32'hBAADBAAD;
    @(negedge clk_i);
    check("post_rst_stall", stall_m_o, 0);
    check("post_rst_req", dmem_req_o, 0);
    @(posedge clk_i);
    #1;
    dmem_rvalid_i = 0;
    check("post_rst_rw", reg_write_w_o, 0);
    check("post_rst_result", result_w_o, 32'h55);
    run_op(1, 0, 1, 32'h200, 0, 5'd14, 0, 2, 32'h600DDA7A, 0);

    for (int n = 0; n < 200; n++) begin
      int          cls;
      logic [31:0] a;
      cls = $urandom_range(0, 3);
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      case (cls)
        0:       run_op(1, 0, 0, a, $urandom, 5'($urandom), 0, 0, 0, 1);
        1:       run_op(1, 0, 1, a, $urandom, 5'($urandom), $urandom_range(0, 3),
                        $urandom_range(1, 3), $urandom, 0);
        2:       run_op(0, 1, 0, a, $urandom, 5'($urandom), $urandom_range(0, 3), 0, 0, 1);
        default: run_op(0, 0, 0, a, $urandom, 5'($urandom), 0, 0, 0, 1);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
